clkdiv_ctrl: RTL and testbench

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

---
 rtl/clkdiv_pkg.sv | 17 +
 rtl/clkdiv_period_cnt.sv | 41 ++++
 rtl/clkdiv_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clkdiv_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants for the clock divider controller: FSM encoding, the
// smallest legal divisor and the high-phase length helper.
package clkdiv_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    localparam int unsigned MIN_DIV = 32'd2;

    // Odd divisors give the extra cycle to the high phase.
    function automatic logic [31:0] high_phase(input logic [31:0] div);
        return div - (div >> 1);
    endfunction

endpackage

// File: rtl/clkdiv_period_cnt.sv
// Period counter: counts 0..div_i-1 while running and flags the wrap edge.
module clkdiv_period_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] cnt_nxt_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // ">=" rather than "==" so a corrupted count still recovers at the next edge.
    assign wrap_o    = run_i && (cnt_q >= (div_i - {{(WIDTH-1){1'b0}}, 1'b1}));
    assign cnt_nxt_o = cnt_d;

    // Next count: held at zero when idle, wraps at the period boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = {WIDTH{1'b0}};
        end else if (wrap_o) begin
            cnt_d = {WIDTH{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider: run/stop FSM, divisor handshake with a
// one-deep pending slot applied only at period boundaries, registered outputs.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DIV_RST = 4
) (
    input  logic             clin,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             clout,
    output logic             tick,
    output logic             busy,
    output logic             cfg_err
);

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] div_q,      div_d;
    logic [WIDTH-1:0] pend_q,     pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clout_q,    clout_d;
    logic             tick_q,     tick_d;
    logic             busy_q,     busy_d;
    logic             ready_q,    ready_d;
    logic             err_q;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] high_s;
    logic             wrap_s;
    logic             xfer_s;
    logic             bad_s;
    logic             good_s;

    clkdiv_period_cnt #(.WIDTH(WIDTH)) u_period_cnt (
        .clk_i     (clin),
        .rst_ni    (rst_n),
        .run_i     (state_q != ST_IDLE),
        .div_i     (div_q),
        .cnt_nxt_o (cnt_nxt_s),
        .wrap_o    (wrap_s)
    );

    assign xfer_s = cfg_valid && ready_q;
    assign bad_s  = xfer_s && (cfg_div < WIDTH'(MIN_DIV));
    assign good_s = xfer_s && !bad_s;

    // FSM and divisor bookkeeping.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        case (state_q)
            ST_IDLE: begin
                if (good_s) div_d = cfg_div;
                else        div_d = div_q;
                if (en) state_d = ST_RUN;
                else    state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (good_s) begin
                    pend_d     = cfg_div;
                    pend_vld_d = 1'b1;
                end else begin
                    pend_d     = pend_q;
                    pend_vld_d = pend_vld_q;
                end
                if (!en)         state_d = ST_STOP;
                else if (good_s) state_d = ST_PEND;
                else             state_d = ST_RUN;
            end
            ST_PEND: begin
                if (wrap_s) begin
                    div_d      = pend_q;
                    pend_vld_d = 1'b0;
                end else begin
                    div_d      = div_q;
                    pend_vld_d = pend_vld_q;
                end
                if (!en)         state_d = ST_STOP;
                else if (wrap_s) state_d = ST_RUN;
                else             state_d = ST_PEND;
            end
            ST_STOP: begin
                // A divisor arriving on the final edge has no later boundary, so it lands in D.
                if (wrap_s && !en) begin
                    state_d    = ST_IDLE;
                    pend_vld_d = 1'b0;
                    if (good_s)          div_d = cfg_div;
                    else if (pend_vld_q) div_d = pend_q;
                    else                 div_d = div_q;
                end else begin
                    if (wrap_s && pend_vld_q) begin
                        div_d      = pend_q;
                        pend_vld_d = 1'b0;
                    end else begin
                        div_d      = div_q;
                        pend_vld_d = pend_vld_q;
                    end
                    if (good_s) begin
                        pend_d     = cfg_div;
                        pend_vld_d = 1'b1;
                    end else begin
                        pend_d = pend_q;
                    end
                    if (en) begin
                        if (pend_vld_d) state_d = ST_PEND;
                        else            state_d = ST_RUN;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                pend_vld_d = 1'b0;
            end
        endcase
    end

    assign high_s = WIDTH'(high_phase(32'(div_d)));

    // Outputs are computed from next state so they line up with the count they describe.
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d != ST_PEND);
        clout_d = busy_d && (cnt_nxt_s < high_s);
        tick_d  = busy_d && (cnt_nxt_s == {WIDTH{1'b0}});
    end

    // State, divisor and output registers.
    always_ff @(posedge clin or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= WIDTH'(DIV_RST);
            pend_q     <= {WIDTH{1'b0}};
            pend_vld_q <= 1'b0;
            clout_q    <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clout_q    <= clout_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            err_q      <= bad_s;
        end
    end

    assign clout     = clout_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: directed scenarios followed by random
// en/config/reset traffic, all compared against a period-level reference model.
module tb_clkdiv_ctrl;

    localparam int unsigned WIDTH = 16;

    logic             clin = 1'b0;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             clout;
    logic             tick;
    logic             busy;
    logic             cfg_err;

    int checks = 0;
    int errors = 0;

    // Reference model: divisor, pending queue, running/stopping flags, position in period.
    int m_div;
    int m_pend[$];
    bit m_on;
    bit m_stop;
    int m_pos;
    bit m_err;

    always #50 clin = ~clin;

    clkdiv_ctrl #(.WIDTH(WIDTH), .DIV_RST(4)) dut (
        .clin      (clin),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .clout     (clout),
        .tick      (tick),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !(m_on && !m_stop && m_pend.size() != 0);
    endfunction

    task automatic model_reset();
        m_div = 4;
        m_pend.delete();
        m_on = 1'b0;
        m_stop = 1'b0;
        m_pos = 0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit v, input int d);
        bit xfer;
        bit good;
        bit bnd;
        xfer  = v && m_ready();
        good  = xfer && (d >= 2);
        m_err = xfer && (d < 2);
        if (!m_on) begin
            if (good) m_div = d;
            if (e) begin
                m_on = 1'b1;
                m_stop = 1'b0;
                m_pos = 0;
            end
        end else begin
            bnd = (m_pos == m_div - 1);
            if (bnd && m_stop && !e) begin
                if (good) m_div = d;
                else if (m_pend.size() != 0) m_div = m_pend[0];
                m_pend.delete();
                m_on = 1'b0;
                m_stop = 1'b0;
                m_pos = 0;
            end else begin
                if (bnd && m_pend.size() != 0) m_div = m_pend.pop_front();
                if (good) begin
                    m_pend.delete();
                    m_pend.push_back(d);
                end
                m_pos = bnd ? 0 : m_pos + 1;
                m_stop = !e;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        bit exp_clout;
        exp_clout = m_on && (m_pos < m_div - m_div / 2);
        check_eq({tag, "_clout"}, {31'd0, clout}, {31'd0, exp_clout});
        check_eq({tag, "_tick"},  {31'd0, tick},  {31'd0, (m_on && m_pos == 0)});
        check_eq({tag, "_busy"},  {31'd0, busy},  {31'd0, m_on});
        check_eq({tag, "_ready"}, {31'd0, cfg_ready}, {31'd0, m_ready()});
        check_eq({tag, "_err"},   {31'd0, cfg_err}, {31'd0, m_err});
    endtask

    task automatic cycle(input bit e, input bit v, input int d);
        en = e;
        cfg_valid = v;
        cfg_div = d[WIDTH-1:0];
        @(posedge clin);
        model_step(e, v, d);
        @(negedge clin);
        check_outs("cyc");
    endtask

    task automatic measure_period(input string tag, input int exp);
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 40) begin
            cycle(1'b1, 1'b0, 0);
            n++;
        end
        n = 0;
        do begin
            cycle(1'b1, 1'b0, 0);
            n++;
        end while (tick !== 1'b1 && n < 40);
        check_eq(tag, n, exp);
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 20 && m_pos != p; i++) cycle(1'b1, 1'b0, 0);
    endtask

    task automatic async_reset();
        #10 rst_n = 1'b0;
        #1;
        check_eq("async_clout", {31'd0, clout}, 32'd0);
        check_eq("async_busy",  {31'd0, busy},  32'd0);
        check_eq("async_ready", {31'd0, cfg_ready}, 32'd1);
        model_reset();
        @(negedge clin);
        check_outs("in_reset");
        rst_n = 1'b1;
    endtask

    bit en_r;

    initial begin
        rst_n = 1'b1;
        en = 1'b0;
        cfg_valid = 1'b0;
        cfg_div = '0;
        model_reset();
        #20 rst_n = 1'b0;
        repeat (2) @(negedge clin);
        check_outs("reset");
        rst_n = 1'b1;

        // Divisor 2 loaded while idle takes effect from the first output edge.
        cycle(1'b0, 1'b1, 2);
        cycle(1'b1, 1'b0, 0);
        check_eq("start_tick", {31'd0, tick}, 32'd1);
        measure_period("period_d2", 2);
        cycle(1'b1, 1'b1, 4);
        measure_period("period_back_d4", 4);

        // Default divisor after reset, running.
        async_reset();
        repeat (3) cycle(1'b1, 1'b0, 0);
        measure_period("period_d4", 4);

        // Illegal divisor is rejected and the period stays the same.
        wait_pos(1);
        cycle(1'b1, 1'b1, 1);
        measure_period("period_after_err", 4);

        // Divisor change mid-period waits for the boundary.
        wait_pos(1);
        cycle(1'b1, 1'b1, 3);
        check_eq("pend_ready", {31'd0, cfg_ready}, 32'd0);
        measure_period("period_d3", 3);
        cycle(1'b1, 1'b1, 4);
        measure_period("period_d4_again", 4);

        // Stop request completes the period; re-enable inside the window keeps running.
        wait_pos(1);
        cycle(1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);
        check_eq("stop_idle_busy", {31'd0, busy}, 32'd0);
        cycle(1'b1, 1'b0, 0);
        wait_pos(1);
        cycle(1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        measure_period("period_resume", 4);

        // Reset during the high phase.
        wait_pos(0);
        async_reset();
        cycle(1'b1, 1'b0, 0);
        measure_period("period_after_rst", 4);

        // Random traffic.
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                if ($urandom_range(0, 9) == 0) en_r = !en_r;
                cycle(en_r, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 7)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
